// File: rtl/vga_stream_capture.sv
// vga_stream_capture
//   Receive side of the VGA pixel stream. Rebuilds row/col from BLANK_n and VS,
//   checks line length and lines per frame, and writes one rectangular window
//   of one locked frame into a pixel RAM write port.
//
// Ports
//   iVGA_CLK, iRST_n          pixel clock, asynchronous active-low reset
//   iHS, iVS, iBLANK_n, iRGB  incoming stream (syncs active low, RGB valid when BLANK_n=1)
//   iCAP_REQ                  capture request, sampled every cycle
//   iERR_CLR                  clears the sticky error flags
//   oROW, oCOL, oPIX_VALID    decoded in-range active pixel
//   oFRAME_START              1-cycle pulse on every VS falling edge
//   oLOCKED                   two consecutive good frames seen
//   oERR_LINE_LEN/CNT         sticky timing errors
//   oWR_EN/ADDR/DATA          pixel RAM write port
//   oCAP_BUSY, oCAP_DONE      capture pending/in progress, window complete pulse
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_SEARCH | after reset, waiting for the first VS fall
// S_VBLANK | VS seen, waiting for the first active line
// S_ACTIVE | inside an active line
// S_HBLANK | between active lines

module vga_stream_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WIN_X    = 120,
  parameter int WIN_Y    = 40,
  parameter int WIN_W    = 400,
  parameter int WIN_H    = 400
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iBLANK_n,
  input  logic [23:0] iRGB,
  input  logic        iCAP_REQ,
  input  logic        iERR_CLR,
  output logic [8:0]  oROW,
  output logic [9:0]  oCOL,
  output logic        oPIX_VALID,
  output logic        oFRAME_START,
  output logic        oLOCKED,
  output logic        oERR_LINE_LEN,
  output logic        oERR_LINE_CNT,
  output logic        oWR_EN,
  output logic [18:0] oWR_ADDR,
  output logic [23:0] oWR_DATA,
  output logic        oCAP_BUSY,
  output logic        oCAP_DONE
);

  // Counters run one past the active size so over-long lines/frames are still flagged.
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] H_SAT = 11'(H_ACTIVE + 1);
  localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SAT = 10'(V_ACTIVE + 1);
  localparam logic [10:0] X_LO  = 11'(WIN_X);
  localparam logic [10:0] X_HI  = 11'(WIN_X + WIN_W - 1);
  localparam logic [9:0]  Y_LO  = 10'(WIN_Y);
  localparam logic [9:0]  Y_HI  = 10'(WIN_Y + WIN_H - 1);

  typedef enum logic [1:0] {S_SEARCH, S_VBLANK, S_ACTIVE, S_HBLANK} state_t;

  state_t      state, state_nxt;
  logic        vs_q, vs_d, blank_q, blank_d;
  logic [23:0] rgb_q;
  logic [10:0] col_cnt, pix_col;
  logic [9:0]  row_cnt;
  logic        frame_bad, good_one;
  logic        cap_pend, cap_act, cap_last;
  logic [18:0] wr_addr_cnt;

  logic vs_fall, bl_rise, bl_fall;
  logic pix_act, pix_ok, in_win, wr_now;
  logic line_end, len_err, frame_end, frame_good, cnt_err, locked_nxt;

  // Line boundaries come from BLANK_n alone, so HS carries no extra information here.
  logic unused_hs;
  assign unused_hs = iHS;

  assign vs_fall   = vs_d & ~vs_q;
  assign bl_rise   = blank_q & ~blank_d;
  assign bl_fall   = blank_d & ~blank_q;
  assign oCAP_BUSY = cap_pend | cap_act;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q    <= 1'b1;
      vs_d    <= 1'b1;
      blank_q <= 1'b0;
      blank_d <= 1'b0;
      rgb_q   <= '0;
    end else begin
      vs_q    <= iVS;
      vs_d    <= vs_q;
      blank_q <= iBLANK_n;
      blank_d <= blank_q;
      rgb_q   <= iRGB;
    end
  end

  // FSM: state register
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) state <= S_SEARCH;
    else         state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (vs_fall) begin
      state_nxt = S_VBLANK;
    end else begin
      case (state)
        S_VBLANK: if (bl_rise) state_nxt = S_ACTIVE;
        S_ACTIVE: if (bl_fall) state_nxt = S_HBLANK;
        S_HBLANK: if (bl_rise) state_nxt = S_ACTIVE;
        default:  ;
      endcase
    end
  end

  // FSM: decoded strobes
  always_comb begin
    // The first pixel of a line arrives together with the BLANK_n rise.
    pix_col    = bl_rise ? 11'd0 : col_cnt;
    pix_act    = (state != S_SEARCH) && blank_q;
    pix_ok     = pix_act && (pix_col < H_ACT) && (row_cnt < V_ACT);
    in_win     = pix_ok && (row_cnt >= Y_LO) && (row_cnt <= Y_HI) &&
                 (pix_col >= X_LO) && (pix_col <= X_HI);
    wr_now     = cap_act && in_win;
    line_end   = (state == S_ACTIVE) && bl_fall;
    len_err    = line_end && (col_cnt != H_ACT);
    frame_end  = vs_fall && (state != S_SEARCH);
    frame_good = !frame_bad && (row_cnt == V_ACT);
    cnt_err    = frame_end && (row_cnt != V_ACT);
    locked_nxt = oLOCKED;
    if (len_err)        locked_nxt = 1'b0;
    else if (frame_end) locked_nxt = frame_good && good_one;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      col_cnt       <= '0;
      row_cnt       <= '0;
      frame_bad     <= 1'b0;
      good_one      <= 1'b0;
      oLOCKED       <= 1'b0;
      oERR_LINE_LEN <= 1'b0;
      oERR_LINE_CNT <= 1'b0;
      oFRAME_START  <= 1'b0;
      oPIX_VALID    <= 1'b0;
      oROW          <= '0;
      oCOL          <= '0;
    end else begin
      if (pix_act) col_cnt <= (pix_col == H_SAT) ? H_SAT : pix_col + 11'd1;

      if (vs_fall)                           row_cnt <= '0;
      else if (line_end && row_cnt != V_SAT) row_cnt <= row_cnt + 10'd1;

      if (vs_fall)      frame_bad <= 1'b0;
      else if (len_err) frame_bad <= 1'b1;

      if (vs_fall)      good_one <= frame_end && frame_good && !len_err;
      else if (len_err) good_one <= 1'b0;

      oLOCKED       <= locked_nxt;
      oERR_LINE_LEN <= len_err | (oERR_LINE_LEN & ~iERR_CLR);
      oERR_LINE_CNT <= cnt_err | (oERR_LINE_CNT & ~iERR_CLR);
      oFRAME_START  <= vs_fall;
      oPIX_VALID    <= pix_ok;
      if (pix_ok) begin
        oROW <= row_cnt[8:0];
        oCOL <= pix_col[9:0];
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cap_pend    <= 1'b0;
      cap_act     <= 1'b0;
      cap_last    <= 1'b0;
      oCAP_DONE   <= 1'b0;
      wr_addr_cnt <= '0;
      oWR_EN      <= 1'b0;
      oWR_ADDR    <= '0;
      oWR_DATA    <= '0;
    end else begin
      oCAP_DONE <= 1'b0;
      cap_last  <= wr_now && (row_cnt == Y_HI) && (pix_col == X_HI);
      oWR_EN    <= wr_now;
      if (wr_now) begin
        oWR_ADDR    <= wr_addr_cnt;
        oWR_DATA    <= rgb_q;
        wr_addr_cnt <= wr_addr_cnt + 19'd1;
      end
      // Busy stays high through the last write and drops with the done pulse.
      if (cap_last) begin
        cap_act   <= 1'b0;
        oCAP_DONE <= 1'b1;
      end else if (vs_fall && oCAP_BUSY) begin
        // Locked at this frame boundary: capture the frame that starts now.
        if (locked_nxt) begin
          cap_act     <= 1'b1;
          cap_pend    <= 1'b0;
          wr_addr_cnt <= '0;
        end else begin
          cap_act  <= 1'b0;
          cap_pend <= 1'b1;
        end
      end else if (cap_act && !locked_nxt) begin
        cap_act  <= 1'b0;
        cap_pend <= 1'b1;
      end else if (iCAP_REQ && !oCAP_BUSY) begin
        cap_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_stream_capture.sv
module tb_vga_stream_capture;

  localparam int H = 16, V = 8, WX = 3, WY = 2, WW = 5, WH = 4;
  localparam int NWIN = WW * WH;

  logic        iVGA_CLK = 1'b0;
  logic        iRST_n, iHS, iVS, iBLANK_n, iCAP_REQ, iERR_CLR;
  logic [23:0] iRGB;
  logic [8:0]  oROW;
  logic [9:0]  oCOL;
  logic        oPIX_VALID, oFRAME_START, oLOCKED, oERR_LINE_LEN, oERR_LINE_CNT;
  logic        oWR_EN, oCAP_BUSY, oCAP_DONE;
  logic [18:0] oWR_ADDR;
  logic [23:0] oWR_DATA;

  vga_stream_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .WIN_X(WX), .WIN_Y(WY), .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iHS(iHS), .iVS(iVS), .iBLANK_n(iBLANK_n),
    .iRGB(iRGB), .iCAP_REQ(iCAP_REQ), .iERR_CLR(iERR_CLR), .oROW(oROW), .oCOL(oCOL),
    .oPIX_VALID(oPIX_VALID), .oFRAME_START(oFRAME_START), .oLOCKED(oLOCKED),
    .oERR_LINE_LEN(oERR_LINE_LEN), .oERR_LINE_CNT(oERR_LINE_CNT), .oWR_EN(oWR_EN),
    .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA), .oCAP_BUSY(oCAP_BUSY), .oCAP_DONE(oCAP_DONE)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  wire [69:0] all_outs = {oROW, oCOL, oPIX_VALID, oFRAME_START, oLOCKED, oERR_LINE_LEN,
                          oERR_LINE_CNT, oWR_EN, oWR_ADDR, oWR_DATA, oCAP_BUSY, oCAP_DONE};

  int n_cmp = 0, n_bad = 0;

  // Scoreboard: expected pixels {row,col} and writes {addr,data}, pushed at drive time.
  logic [18:0] pix_q[$];
  logic [42:0] wr_q[$];
  logic [18:0] mon_ep;
  logic [42:0] mon_ew;

  int          fs_cnt = 0, frame_pix = 0, fs_pix = 0, el_rises = 0, wr_cnt = 0, done_cnt = 0;
  logic        fs_lock = 0, fs_lock_prev = 0, fs_errc = 0, fs_errc_prev = 0;
  logic        el_lock = 0, el_lock_prev = 0, dn_busy = 0, dn_prev_wr = 0;
  logic        prev_lock = 0, prev_errc = 0, prev_errl = 0, prev_wr = 0;
  logic [18:0] prev_addr = 0, dn_prev_addr = 0;

  always @(negedge iVGA_CLK) begin
    if (oPIX_VALID) begin
      frame_pix++;
      n_cmp++;
      if (pix_q.size() == 0) begin
        n_bad++;
        $display("FAIL pix_unexpected: got row %0d col %0d, required no pixel", oROW, oCOL);
      end else begin
        mon_ep = pix_q.pop_front();
        if ({oROW, oCOL} !== mon_ep) begin
          n_bad++;
          $display("FAIL pix_pos: got row %0d col %0d, required row %0d col %0d",
                   oROW, oCOL, mon_ep[18:10], mon_ep[9:0]);
        end
      end
    end
    if (oWR_EN) begin
      wr_cnt++;
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got addr %0d data %h, required no write", oWR_ADDR, oWR_DATA);
      end else begin
        mon_ew = wr_q.pop_front();
        if ({oWR_ADDR, oWR_DATA} !== mon_ew) begin
          n_bad++;
          $display("FAIL wr_data: got addr %0d data %h, required addr %0d data %h",
                   oWR_ADDR, oWR_DATA, mon_ew[42:24], mon_ew[23:0]);
        end
      end
    end
    if (oFRAME_START) begin
      fs_cnt++;
      fs_pix = frame_pix;
      frame_pix = 0;
      fs_lock = oLOCKED;
      fs_lock_prev = prev_lock;
      fs_errc = oERR_LINE_CNT;
      fs_errc_prev = prev_errc;
    end
    if (oERR_LINE_LEN && !prev_errl) begin
      el_rises++;
      el_lock = oLOCKED;
      el_lock_prev = prev_lock;
    end
    if (oCAP_DONE) begin
      done_cnt++;
      dn_busy = oCAP_BUSY;
      dn_prev_wr = prev_wr;
      dn_prev_addr = prev_addr;
    end
    prev_lock = oLOCKED;
    prev_errc = oERR_LINE_CNT;
    prev_errl = oERR_LINE_LEN;
    prev_wr   = oWR_EN;
    prev_addr = oWR_ADDR;
  end

  task automatic cyc(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
    @(negedge iVGA_CLK);
    iHS = hs; iVS = vs; iBLANK_n = bl; iRGB = rgb;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic pulse_req();
    @(negedge iVGA_CLK); iCAP_REQ = 1'b1;
    @(negedge iVGA_CLK); iCAP_REQ = 1'b0;
  endtask

  // One frame starting with its VS pulse; optional short line, capture window, reset abort row.
  task automatic send_frame(input int nlines, input int short_line, input bit cap,
                            input int abort_row, output bit aborted);
    logic [23:0] px;
    int len;
    aborted = 1'b0;
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 24'h0);
    idle(3);
    for (int r = 0; r < nlines; r++) begin
      if (r == abort_row) begin
        aborted = 1'b1;
        return;
      end
      len = (r == short_line) ? H - 1 : H;
      for (int c = 0; c < len; c++) begin
        px = 24'($urandom());
        pix_q.push_back({9'(r), 10'(c)});
        if (cap && r >= WY && r < WY + WH && c >= WX && c < WX + WW)
          wr_q.push_back({19'((r - WY) * WW + (c - WX)), px});
        cyc(1'b1, 1'b1, 1'b1, px);
      end
      idle(1);
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 24'h0);
      idle(2);
    end
    idle(3);
  endtask

  task automatic test_reset();
    iRST_n = 1'b0; iHS = 1'b1; iVS = 1'b1; iBLANK_n = 1'b0; iRGB = '0;
    iCAP_REQ = 1'b0; iERR_CLR = 1'b0;
    repeat (3) @(negedge iVGA_CLK);
    n_cmp++;
    if (all_outs !== 70'd0) begin n_bad++; $display("FAIL reset_outs: got %h required 0", all_outs); end
    iRST_n = 1'b1;
    idle(4);
    n_cmp++;
    if (all_outs !== 70'd0) begin n_bad++; $display("FAIL idle_outs: got %h required 0", all_outs); end
  endtask

  task automatic test_lock();
    bit ab;
    for (int f = 1; f <= 3; f++) begin
      send_frame(V, -1, 1'b0, -1, ab);
      n_cmp++;
      if (fs_cnt !== f) begin n_bad++; $display("FAIL fs_count: got %0d required %0d", fs_cnt, f); end
      n_cmp++;
      if (fs_lock !== (f == 3)) begin
        n_bad++; $display("FAIL lock_at_vs%0d: got %0b required %0b", f, fs_lock, f == 3);
      end
      n_cmp++;
      if (fs_pix !== ((f == 1) ? 0 : H * V)) begin
        n_bad++; $display("FAIL pix_per_frame%0d: got %0d required %0d", f, fs_pix, (f == 1) ? 0 : H * V);
      end
    end
    n_cmp++;
    if (fs_lock_prev !== 1'b0) begin n_bad++; $display("FAIL lock_before_vs3: got 1 required 0"); end
    n_cmp++;
    if ({oERR_LINE_LEN, oERR_LINE_CNT} !== 2'b00) begin
      n_bad++; $display("FAIL nominal_errs: got %b required 00", {oERR_LINE_LEN, oERR_LINE_CNT});
    end
  endtask

  task automatic test_line_len();
    bit ab;
    int e0 = el_rises;
    send_frame(V, 3, 1'b0, -1, ab);
    n_cmp++;
    if (el_rises !== e0 + 1) begin n_bad++; $display("FAIL len_err_rises: got %0d required %0d", el_rises, e0 + 1); end
    n_cmp++;
    if ({el_lock_prev, el_lock} !== 2'b10) begin
      n_bad++; $display("FAIL lock_drop_at_len_err: got %b required 10", {el_lock_prev, el_lock});
    end
    n_cmp++;
    if ({oERR_LINE_LEN, oLOCKED} !== 2'b10) begin
      n_bad++; $display("FAIL after_short_line: got %b required 10", {oERR_LINE_LEN, oLOCKED});
    end
    for (int g = 1; g <= 3; g++) begin
      send_frame(V, -1, 1'b0, -1, ab);
      n_cmp++;
      if (fs_lock !== (g == 3)) begin
        n_bad++; $display("FAIL relock_vs%0d: got %0b required %0b", g, fs_lock, g == 3);
      end
    end
    n_cmp++;
    if (oERR_LINE_CNT !== 1'b0) begin n_bad++; $display("FAIL cnt_err_from_len: got 1 required 0"); end
  endtask

  task automatic test_line_cnt();
    bit ab;
    send_frame(V - 1, -1, 1'b0, -1, ab);
    send_frame(V, -1, 1'b0, -1, ab);
    n_cmp++;
    if ({fs_errc_prev, fs_errc, fs_lock} !== 3'b010) begin
      n_bad++; $display("FAIL cnt_err_at_vs: got %b required 010", {fs_errc_prev, fs_errc, fs_lock});
    end
    send_frame(V, -1, 1'b0, -1, ab);
    send_frame(V, -1, 1'b0, -1, ab);
    n_cmp++;
    if ({oERR_LINE_LEN, oERR_LINE_CNT, oLOCKED} !== 3'b111) begin
      n_bad++; $display("FAIL before_clear: got %b required 111", {oERR_LINE_LEN, oERR_LINE_CNT, oLOCKED});
    end
    @(negedge iVGA_CLK); iERR_CLR = 1'b1;
    @(negedge iVGA_CLK); iERR_CLR = 1'b0;
    n_cmp++;
    if ({oERR_LINE_LEN, oERR_LINE_CNT, oLOCKED} !== 3'b001) begin
      n_bad++; $display("FAIL after_clear: got %b required 001", {oERR_LINE_LEN, oERR_LINE_CNT, oLOCKED});
    end
  endtask

  task automatic test_capture();
    bit ab;
    int w0 = wr_cnt, d0 = done_cnt;
    pulse_req();
    n_cmp++;
    if (oCAP_BUSY !== 1'b1) begin n_bad++; $display("FAIL busy_after_req: got 0 required 1"); end
    pulse_req();
    send_frame(V, -1, 1'b1, -1, ab);
    n_cmp++;
    if (wr_cnt - w0 !== NWIN) begin n_bad++; $display("FAIL cap_writes: got %0d required %0d", wr_cnt - w0, NWIN); end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL cap_done_count: got %0d required 1", done_cnt - d0); end
    n_cmp++;
    if ({dn_prev_wr, dn_busy} !== 2'b10) begin
      n_bad++; $display("FAIL done_timing: got prev_wr,busy %b required 10", {dn_prev_wr, dn_busy});
    end
    n_cmp++;
    if (dn_prev_addr !== 19'(NWIN - 1)) begin
      n_bad++; $display("FAIL last_addr: got %0d required %0d", dn_prev_addr, NWIN - 1);
    end
    send_frame(V, -1, 1'b0, -1, ab);
    n_cmp++;
    if ({wr_cnt - w0, done_cnt - d0} !== {NWIN, 1}) begin
      n_bad++; $display("FAIL no_recapture: got writes %0d dones %0d required %0d 1", wr_cnt - w0, done_cnt - d0, NWIN);
    end
  endtask

  task automatic test_unlocked_capture();
    bit ab;
    int w0, d0;
    send_frame(V, 3, 1'b0, -1, ab);
    pulse_req();
    w0 = wr_cnt; d0 = done_cnt;
    for (int g = 1; g <= 2; g++) begin
      send_frame(V, -1, 1'b0, -1, ab);
      n_cmp++;
      if ({wr_cnt - w0, 31'(oCAP_BUSY)} !== {32'd0, 31'd1}) begin
        n_bad++; $display("FAIL pending_frame%0d: got writes %0d busy %0b required 0 1", g, wr_cnt - w0, oCAP_BUSY);
      end
    end
    send_frame(V, -1, 1'b1, -1, ab);
    n_cmp++;
    if ({wr_cnt - w0, done_cnt - d0} !== {NWIN, 1}) begin
      n_bad++; $display("FAIL late_capture: got writes %0d dones %0d required %0d 1", wr_cnt - w0, done_cnt - d0, NWIN);
    end
    n_cmp++;
    if (oCAP_BUSY !== 1'b0) begin n_bad++; $display("FAIL busy_after_late_cap: got 1 required 0"); end
  endtask

  task automatic test_reset_mid_capture();
    bit ab;
    int w0 = wr_cnt, d0 = done_cnt;
    pulse_req();
    send_frame(V, -1, 1'b1, WY + 2, ab);
    n_cmp++;
    if ({ab, oCAP_BUSY, 32'(wr_cnt - w0)} !== {1'b1, 1'b1, 32'(2 * WW)}) begin
      n_bad++; $display("FAIL mid_capture: got abort %0b busy %0b writes %0d required 1 1 %0d", ab, oCAP_BUSY, wr_cnt - w0, 2 * WW);
    end
    iRST_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== 70'd0) begin n_bad++; $display("FAIL async_reset: got %h required 0", all_outs); end
    iHS = 1'b1; iVS = 1'b1; iBLANK_n = 1'b0; iRGB = '0;
    repeat (3) @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    idle(4);
    n_cmp++;
    if (done_cnt !== d0) begin n_bad++; $display("FAIL done_after_abort: got %0d required %0d", done_cnt, d0); end
    send_frame(V, -1, 1'b0, -1, ab);
    n_cmp++;
    if ({fs_lock, oERR_LINE_CNT, oCAP_BUSY} !== 3'b000) begin
      n_bad++; $display("FAIL search_first_vs: got %b required 000", {fs_lock, oERR_LINE_CNT, oCAP_BUSY});
    end
    send_frame(V, -1, 1'b0, -1, ab);
    n_cmp++;
    if ({fs_lock, fs_errc} !== 2'b00) begin
      n_bad++; $display("FAIL first_frame_after_reset: got %b required 00", {fs_lock, fs_errc});
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_line_len();
    test_line_cnt();
    test_capture();
    test_unlocked_capture();
    test_reset_mid_capture();
    idle(4);
    n_cmp++;
    if (pix_q.size() != 0) begin n_bad++; $display("FAIL pix_left: got %0d required 0", pix_q.size()); end
    n_cmp++;
    if (wr_q.size() != 0) begin n_bad++; $display("FAIL wr_left: got %0d required 0", wr_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
